// File: rtl/merge2.sv
// Bottom-up merge pass: combines eight sorted 2-element runs into four sorted
// 4-element runs, reading a 16-entry buffer and writing the next buffer in order.
module merge2 (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_start,
  output logic        ap_done,
  input  logic        ap_continue,
  output logic        ap_idle,
  output logic        ap_ready,
  output logic [3:0]  input1_address0,
  output logic        input1_ce0,
  input  logic [31:0] input1_q0,
  output logic [3:0]  input1_address1,
  output logic        input1_ce1,
  input  logic [31:0] input1_q1,
  output logic [3:0]  output1_address0,
  output logic        output1_ce0,
  output logic        output1_we0,
  output logic [31:0] output1_d0
);

  typedef enum logic [2:0] {
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b100
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [4:0] i;
  logic [4:0] base;
  logic [4:0] p1;
  logic [4:0] p2;
  logic       ap_done_reg;
  logic       pass_end;
  logic       take_left;
  logic [4:0] p1_upd;
  logic [4:0] p2_upd;
  logic       group_done;

  // An exhausted right run forces the left side, so wrapped reads at address 16 are never used.
  always_comb begin
    pass_end   = (state == S2) && (i == 5'd16);
    take_left  = (p2 == base + 5'd4) ||
                 ((p1 < base + 5'd2) && ($signed(input1_q0) <= $signed(input1_q1)));
    p1_upd     = take_left ? p1 + 5'd1 : p1;
    p2_upd     = take_left ? p2 : p2 + 5'd1;
    group_done = (p1_upd == base + 5'd2) && (p2_upd == base + 5'd4);
  end

  always_comb begin
    state_next       = state;
    input1_ce0       = 1'b0;
    input1_ce1       = 1'b0;
    input1_address0  = p1[3:0];
    input1_address1  = p2[3:0];
    output1_ce0      = 1'b0;
    output1_we0      = 1'b0;
    output1_address0 = i[3:0];
    output1_d0       = take_left ? input1_q0 : input1_q1;
    case (state)
      S1: begin
        if (ap_start && !ap_done_reg) state_next = S2;
      end
      S2: begin
        if (i == 5'd16) begin
          state_next = S1;
        end else begin
          input1_ce0 = 1'b1;
          input1_ce1 = 1'b1;
          state_next = S3;
        end
      end
      S3: begin
        output1_ce0 = 1'b1;
        output1_we0 = 1'b1;
        state_next  = S2;
      end
      default: state_next = S1;
    endcase
    ap_done  = pass_end | ap_done_reg;
    ap_ready = pass_end;
    ap_idle  = (state == S1) && !ap_start;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state       <= S1;
      ap_done_reg <= 1'b0;
      i           <= 5'd0;
      base        <= 5'd0;
      p1          <= 5'd0;
      p2          <= 5'd0;
    end else begin
      state <= state_next;
      if (ap_continue) ap_done_reg <= 1'b0;
      else if (pass_end) ap_done_reg <= 1'b1;
      case (state)
        S1: begin
          if (ap_start && !ap_done_reg) begin
            i    <= 5'd0;
            base <= 5'd0;
            p1   <= 5'd0;
            p2   <= 5'd2;
          end
        end
        S3: begin
          i <= i + 5'd1;
          // Both runs drained: step to the next pair of runs.
          if (group_done) begin
            base <= base + 5'd4;
            p1   <= base + 5'd4;
            p2   <= base + 5'd6;
          end else begin
            p1 <= p1_upd;
            p2 <= p2_upd;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/merge2.md
MERGE2 -- requirements
Module: merge2

Interface
REQ-001 SHALL have port ap_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port ap_rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port ap_start, input, 1 bit: request to run one merge pass.
REQ-004 SHALL have port ap_done, output, 1 bit: pass complete; stays high until ap_continue is seen.
REQ-005 SHALL have port ap_continue, input, 1 bit: downstream stage has taken the result.
REQ-006 SHALL have ports ap_idle and ap_ready, outputs, 1 bit each: idle waiting for start; all input reads finished.
REQ-007 SHALL have ports input1_address0 and input1_address1, outputs, 4 bits each: read addresses into the 16-entry ping-pong buffer that merge1 fills.
REQ-008 SHALL have ports input1_ce0 and input1_ce1, outputs, 1 bit each; input1_q0 and input1_q1, inputs, 32 bits each: read data, valid one cycle after the enable.
REQ-009 SHALL have port output1_address0, output, 4 bits; output1_ce0 and output1_we0, outputs, 1 bit each; output1_d0, output, 32 bits: write port to the next ping-pong buffer.

Function
REQ-010 SHALL treat input1 as eight sorted signed 32-bit runs of width 2, and merge adjacent run pairs into four sorted runs of width 4 in output1.
REQ-011 SHALL use a one-hot FSM with states S1 IDLE, S2 READ and S3 WRITE.
REQ-012 SHALL move from S1 to S2 only when ap_start=1 and ap_done_reg=0. On that edge it loads i=0, base=0, p1=0 and p2=2.
REQ-013 In S2, SHALL assert input1_ce0 and input1_ce1, drive address0=p1[3:0] and address1=p2[3:0], then go to S3. The exception is i==16, which goes to S1 instead.
REQ-014 In S3, SHALL take the left element when p2==base+4, or when p1<base+2 and $signed(q0) <= $signed(q1). Otherwise it SHALL take the right element. Ties go to the left element (stable merge).
REQ-015 In S3, SHALL assert output1_ce0 and output1_we0, drive output1_address0=i[3:0] and output1_d0 with the chosen element, increment the chosen pointer, set i<=i+1, and go to S2.
REQ-016 In S3, when both runs are exhausted after the update, SHALL set base<=base+4, p1<=base+4 and p2<=base+6.
REQ-017 Pointers SHALL be 5 bits wide. A read at an address equal to 16 wraps to address 0, and its data SHALL be ignored by REQ-014.
REQ-018 SHALL drive output1_ce0 and output1_we0 low in every state other than S3, and drive input read enables low outside S2.
REQ-019 SHALL assert ap_done=ap_ready=1 combinationally in S2 when i==16. In other cycles ap_done equals ap_done_reg.
REQ-020 SHALL set ap_done_reg on the completion edge when ap_continue=0, and clear it on any edge with ap_continue=1.
REQ-021 SHALL assert ap_idle when in S1 with ap_start=0.
REQ-022 Latency SHALL be 34 cycles from the start-accept cycle to the done cycle inclusive: 1 + 16×2 + 1.
REQ-023 SHALL perform exactly 16 writes per pass, to addresses 0..15 in order.
REQ-024 ap_start held high while ap_done_reg=1 SHALL NOT start a new pass.

Reset
REQ-025 With ap_rst=1 the block SHALL immediately enter S1, clear ap_done_reg, and deassert ap_done, ap_ready and all ce/we outputs.
REQ-026 Reset mid-pass SHALL abandon the pass with no further writes. Datapath registers need not be cleared because they are reloaded at start.
REQ-027 After reset release with ap_start=0, ap_idle SHALL equal 1.

Verification
REQ-028 Input {1,5, 2,3, 0,9, 4,4, -3,7, -8,2, 10,11, 6,12}, start pulse -> output {1,2,3,5, 0,4,4,9, -8,-3,2,7, 6,10,11,12}, ap_done in the 34th cycle.
REQ-029 Equal keys: input all 7 -> output all 7 with the left-first write order; check the element source for each cycle via the ports.
REQ-030 Left run all greater than right, e.g. {9,10, 1,2} -> {1,2,9,10}; the left-exhausted branch must never read beyond base+2.
REQ-031 ap_continue held low for 5 cycles after done -> ap_done stays 1 and a held ap_start is ignored; raising ap_continue lets the next start be accepted.
REQ-032 Assert ap_rst during the 10th S3 -> no write that cycle, S1 with ap_idle=1 on release; a fresh pass gives the full correct result.
REQ-033 Exactly 16 write strobes and 32 read-enable cycles per pass, with addresses compared against the expected sequence.
